// File: rtl/eth_pcs_rx_sync_ctrl.sv
// 10GBASE-R receive block-lock controller and BER monitor.
// Watches 2-bit sync headers from the RX gearbox. While unaligned it asks the
// gearbox for a one-cycle bit slip. It reports block_lock and hi_ber
// downstream, and keeps a saturating count of invalid headers seen while locked.
module eth_pcs_rx_sync_ctrl #(
    parameter int N_LOCK_GOOD = 64,     // good headers to lock; also locked test window
    parameter int N_SLIP_BAD  = 16,     // bad headers per locked window that drop lock
    parameter int SLIP_WAIT   = 4,      // header events ignored after a slip
    parameter int BER_WINDOW  = 19531,  // header events per BER window
    parameter int BER_THRESH  = 16,     // bad headers per BER window for hi_ber
    parameter int W_SYNC      = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic              i_grbx_hdr_valid,
    input  logic [W_SYNC-1:0] i_grbx_hdr,
    output logic              o_grbx_slip,
    output logic              o_block_lock,
    output logic              o_hi_ber,
    output logic [7:0]        o_err_cnt
);

    localparam int SH_W   = $clog2(N_LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(N_SLIP_BAD + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int WIN_W  = $clog2(BER_WINDOW + 1);
    localparam int BER_W  = $clog2(BER_THRESH + 1);

    typedef enum logic [1:0] {
        ST_TEST = 2'd0,
        ST_SLIP = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SH_W-1:0]    sh_cnt, sh_nxt, sh_inc;
    logic [BAD_W-1:0]   bad_cnt, bad_nxt, bad_inc;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt, wait_inc;
    logic               lock_nxt;

    logic [WIN_W-1:0]   win_cnt, win_nxt, win_inc;
    logic [BER_W-1:0]   ber_cnt, ber_nxt, ber_inc;
    logic               hi_ber_nxt;
    logic               ber_active;

    logic               ev;
    logic               hdr_ok;

    // A header event is a qualified header; nothing advances without one.
    assign ev     = i_clk_en & i_grbx_hdr_valid;
    assign hdr_ok = (i_grbx_hdr == W_SYNC'(1)) || (i_grbx_hdr == W_SYNC'(2));

    assign sh_inc   = sh_cnt + SH_W'(1);
    assign bad_inc  = hdr_ok ? bad_cnt : bad_cnt + BAD_W'(1);
    assign wait_inc = wait_cnt + WAIT_W'(1);

    // Lock FSM next-state: hunt for lock, slip on error, then let the gearbox settle.
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_cnt;
        bad_nxt   = bad_cnt;
        wait_nxt  = wait_cnt;
        lock_nxt  = o_block_lock;
        case (state)
            ST_TEST: begin
                if (ev) begin
                    if (!o_block_lock) begin
                        // Unlocked: any bad header means the alignment is wrong.
                        if (!hdr_ok) begin
                            state_nxt = ST_SLIP;
                        end else if (sh_inc == SH_W'(N_LOCK_GOOD)) begin
                            lock_nxt = 1'b1;
                            sh_nxt   = '0;
                            bad_nxt  = '0;
                        end else begin
                            sh_nxt = sh_inc;
                        end
                    end else begin
                        // Locked: tolerate some bad headers per window; loss wins a tie.
                        if (bad_inc == BAD_W'(N_SLIP_BAD)) begin
                            lock_nxt  = 1'b0;
                            state_nxt = ST_SLIP;
                        end else if (sh_inc == SH_W'(N_LOCK_GOOD)) begin
                            sh_nxt  = '0;
                            bad_nxt = '0;
                        end else begin
                            sh_nxt  = sh_inc;
                            bad_nxt = bad_inc;
                        end
                    end
                end
            end
            ST_SLIP: begin
                // Exactly one clock, independent of the enable strobe.
                sh_nxt    = '0;
                bad_nxt   = '0;
                wait_nxt  = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ev) begin
                    if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
                        wait_nxt  = '0;
                        state_nxt = ST_TEST;
                    end else begin
                        wait_nxt = wait_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_TEST;
                sh_nxt    = '0;
                bad_nxt   = '0;
                wait_nxt  = '0;
                lock_nxt  = 1'b0;
            end
        endcase
    end

    // Lock FSM state and its counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_TEST;
            sh_cnt       <= '0;
            bad_cnt      <= '0;
            wait_cnt     <= '0;
            o_block_lock <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_nxt;
            bad_cnt      <= bad_nxt;
            wait_cnt     <= wait_nxt;
            o_block_lock <= lock_nxt;
        end
    end

    // The slip pulse is registered so it is high only during the SLIP cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_grbx_slip <= 1'b0;
        end else begin
            o_grbx_slip <= (state_nxt == ST_SLIP);
        end
    end

    // Saturating count of bad headers seen while locked; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err_cnt <= '0;
        end else if (ev && o_block_lock && !hdr_ok && (o_err_cnt != 8'hff)) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

    // The BER monitor runs only while lock is held across the edge. The event
    // that acquires lock is not counted, and the event that loses lock clears
    // the monitor at once.
    assign ber_active = o_block_lock & lock_nxt;
    assign win_inc    = win_cnt + WIN_W'(1);
    assign ber_inc    = (!hdr_ok && (ber_cnt != BER_W'(BER_THRESH))) ? ber_cnt + BER_W'(1)
                                                                      : ber_cnt;

    // BER window next-state: hi_ber rises at threshold and clears only at the
    // end of a window that stayed below it.
    always_comb begin
        win_nxt    = win_cnt;
        ber_nxt    = ber_cnt;
        hi_ber_nxt = o_hi_ber;
        if (!ber_active) begin
            win_nxt    = '0;
            ber_nxt    = '0;
            hi_ber_nxt = 1'b0;
        end else if (ev) begin
            if (ber_inc == BER_W'(BER_THRESH)) begin
                hi_ber_nxt = 1'b1;
            end
            if (win_inc == WIN_W'(BER_WINDOW)) begin
                win_nxt = '0;
                ber_nxt = '0;
                if (ber_inc != BER_W'(BER_THRESH)) begin
                    hi_ber_nxt = 1'b0;
                end
            end else begin
                win_nxt = win_inc;
                ber_nxt = ber_inc;
            end
        end
    end

    // BER monitor registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            win_cnt  <= '0;
            ber_cnt  <= '0;
            o_hi_ber <= 1'b0;
        end else begin
            win_cnt  <= win_nxt;
            ber_cnt  <= ber_nxt;
            o_hi_ber <= hi_ber_nxt;
        end
    end

endmodule

// File: tb/tb_eth_pcs_rx_sync_ctrl.sv
// Self-checking bench for eth_pcs_rx_sync_ctrl (BER_WINDOW shortened to 100).
// Each scenario pushes the expected outputs for a cycle, drives that cycle,
// then pops the entry and compares it against the DUT.
module tb_eth_pcs_rx_sync_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_clk_en = 1'b0;
    logic       i_grbx_hdr_valid = 1'b0;
    logic [1:0] i_grbx_hdr = 2'b00;
    logic       o_grbx_slip;
    logic       o_block_lock;
    logic       o_hi_ber;
    logic [7:0] o_err_cnt;

    typedef struct packed {
        logic       slip;
        logic       lock;
        logic       hi_ber;
        logic [7:0] err;
    } obs_t;

    typedef struct {
        obs_t  v;
        string nm;
        int    n;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    eth_pcs_rx_sync_ctrl #(
        .N_LOCK_GOOD(64),
        .N_SLIP_BAD (16),
        .SLIP_WAIT  (4),
        .BER_WINDOW (100),
        .BER_THRESH (16),
        .W_SYNC     (2)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clk_en        (i_clk_en),
        .i_grbx_hdr_valid(i_grbx_hdr_valid),
        .i_grbx_hdr      (i_grbx_hdr),
        .o_grbx_slip     (o_grbx_slip),
        .o_block_lock    (o_block_lock),
        .o_hi_ber        (o_hi_ber),
        .o_err_cnt       (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, then return just after the rising edge.
    task automatic tick(input logic r, input logic en, input logic hv, input logic [1:0] h);
        i_reset = r; i_clk_en = en; i_grbx_hdr_valid = hv; i_grbx_hdr = h;
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int n, input logic s, input logic l,
                              input logic h, input int e);
        sb_t x;
        x.v  = {s, l, h, 8'(e)};
        x.nm = nm;
        x.n  = n;
        sb_q.push_back(x);
    endtask

    task automatic test_reset();
        sb_t  x;
        obs_t o;
        for (int i = 1; i <= 2; i++) begin
            expect_out("reset", i, 1'b0, 1'b0, 1'b0, 0);
            tick(1'b1, 1'b1, 1'b1, 2'b11);
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    // 64 good headers lock on the 64th; no slip, no BER, no errors.
    task automatic test_clean_lock();
        sb_t  x;
        obs_t o;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 70; i++) begin
            expect_out("clean_lock", i, 1'b0, i >= 64, 1'b0, 0);
            tick(1'b0, 1'b1, 1'b1, 2'b01);
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    // Bad header at ev 10 slips once; ev 11-14 ignored even if bad; lock at ev 78.
    // The gearbox presents no event during the slip cycle itself.
    task automatic test_misaligned();
        sb_t        x;
        obs_t       o;
        logic [1:0] h;
        int         step;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        step = 0;
        for (int i = 1; i <= 78; i++) begin
            if (i == 10)                h = 2'b11;
            else if (i >= 11 && i <= 14) h = (i % 2 == 1) ? 2'b00 : 2'b11;
            else                        h = 2'b01;
            for (int c = 0; c < ((i == 10) ? 2 : 1); c++) begin
                step++;
                if (c == 0) begin
                    expect_out("misaligned", step, i == 10, i >= 78, 1'b0, 0);
                    tick(1'b0, 1'b1, 1'b1, h);
                end else begin
                    expect_out("misaligned", step, 1'b0, 1'b0, 1'b0, 0);
                    tick(1'b0, 1'b0, 1'b1, 2'b11);
                end
                x = sb_q.pop_front();
                o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
                checks++;
                if (o !== x.v) begin
                    errors++;
                    $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                             x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
                end
            end
        end
    endtask

    // Lock, then every 4th header bad: lock falls on the 16th bad, one slip follows.
    task automatic test_loss_of_lock();
        sb_t  x;
        obs_t o;
        int   j;
        logic inv;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 134; i++) begin
            if (i <= 64) begin
                expect_out("loss_acq", i, 1'b0, i >= 64, 1'b0, 0);
                tick(1'b0, 1'b1, 1'b1, 2'b01);
            end else if (i <= 128) begin
                j   = i - 64;
                inv = (j % 4 == 0);
                expect_out("loss_win", j, j == 64, j < 64, 1'b0, j / 4);
                tick(1'b0, 1'b1, 1'b1, inv ? 2'b11 : 2'b01);
            end else begin
                expect_out("loss_after", i - 128, 1'b0, 1'b0, 1'b0, 16);
                tick(1'b0, 1'b1, 1'b1, 2'b01);
            end
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    // 15 bad per 64-window holds lock for 3 windows (err=45). With the
    // 100-event BER window the 16th bad since lock (ev 68) raises hi_ber,
    // and no window ends below threshold before ev 192.
    task automatic test_lock_hold();
        sb_t  x;
        obs_t o;
        int   k, j, nerr;
        logic inv;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        nerr = 0;
        for (int i = 1; i <= 256; i++) begin
            k   = i - 64;
            j   = (k >= 1) ? ((k - 1) % 64) + 1 : 0;
            inv = (k >= 1) && (j % 4 == 0) && (j <= 60);
            if (inv) nerr++;
            expect_out("lock_hold", i, 1'b0, i >= 64, k >= 68, nerr);
            tick(1'b0, 1'b1, 1'b1, inv ? 2'b00 : 2'b10);
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    // Bad at ev 57..72 (8 per lock window, so lock holds): hi_ber at ev 72,
    // kept past the saturated window end at 100, cleared at 200 (only 2 bad).
    task automatic test_hi_ber();
        sb_t  x;
        obs_t o;
        int   k, nerr;
        logic inv;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        nerr = 0;
        for (int i = 1; i <= 264; i++) begin
            k   = i - 64;
            inv = (k >= 57 && k <= 72) || (k == 150) || (k == 160);
            if (inv) nerr++;
            expect_out("hi_ber", k, 1'b0, i >= 64, (k >= 72) && (k < 200), nerr);
            tick(1'b0, 1'b1, 1'b1, inv ? 2'b11 : 2'b01);
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    // One qualified event per 3 cycles; bad headers on unqualified cycles are ignored.
    task automatic test_clk_en();
        sb_t  x;
        obs_t o;
        int   nev;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        nev = 0;
        for (int c = 0; c < 3 * 70; c++) begin
            if (c % 3 == 0) nev++;
            expect_out("clk_en", c, 1'b0, nev >= 64, 1'b0, 0);
            case (c % 3)
                0:       tick(1'b0, 1'b1, 1'b1, 2'b01);
                1:       tick(1'b0, 1'b0, 1'b1, 2'b11);
                default: tick(1'b0, 1'b1, 1'b0, 2'b00);
            endcase
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    // Reset during SLIP_WAIT, during SLIP and with hi_ber high; the FSM must come back in TEST.
    task automatic test_reset_mid();
        sb_t        x;
        obs_t       o;
        logic       rs [1:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] hs [1:9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
        logic       ss [1:9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int         k;
        logic       inv;
        tick(1'b1, 1'b0, 1'b0, 2'b00);
        for (int s = 1; s <= 9; s++) begin
            expect_out("rst_slip", s, ss[s], 1'b0, 1'b0, 0);
            tick(rs[s], 1'b1, 1'b1, hs[s]);
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
        for (int i = 1; i <= 138; i++) begin
            k   = i - 64;
            inv = (k >= 57 && k <= 72);
            if (i <= 136) begin
                expect_out("rst_ber", i, 1'b0, i >= 64, k >= 72, (k > 56) ? k - 56 : 0);
                tick(1'b0, 1'b1, 1'b1, inv ? 2'b00 : 2'b01);
            end else begin
                expect_out("rst_ber", i, 1'b0, 1'b0, 1'b0, 0);
                tick(i == 137, 1'b1, 1'b1, (i == 137) ? 2'b11 : 2'b01);
            end
            x = sb_q.pop_front();
            o = {o_grbx_slip, o_block_lock, o_hi_ber, o_err_cnt};
            checks++;
            if (o !== x.v) begin
                errors++;
                $display("FAIL %s[%0d]: got slip=%b lock=%b hi_ber=%b err=%0d, want slip=%b lock=%b hi_ber=%b err=%0d",
                         x.nm, x.n, o.slip, o.lock, o.hi_ber, o.err, x.v.slip, x.v.lock, x.v.hi_ber, x.v.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_misaligned();
        test_loss_of_lock();
        test_lock_hold();
        test_hi_ber();
        test_clk_en();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
